// File: rtl/wb_map_pkg.sv
// Wishbone address map, engine ID and sequencer state encoding for wb_job_sequencer.
// WB_JOB_ID_CHECK_EN adds the post-reset ID check states to the state enum.
package wb_map_pkg;

    localparam logic [7:0]  ADDR_W0_LO   = 8'h51;
    localparam logic [7:0]  ADDR_W0_HI   = 8'h52;
    localparam logic [7:0]  ADDR_W0_TOP  = 8'h53;
    localparam logic [7:0]  ADDR_W1_LO   = 8'h54;
    localparam logic [7:0]  ADDR_W1_HI   = 8'h55;
    localparam logic [7:0]  ADDR_W1_TOP  = 8'h56;
    localparam logic [7:0]  ADDR_FEAT_LO = 8'hC0;
    localparam logic [7:0]  ADDR_FEAT_HI = 8'hC8;
    localparam logic [7:0]  ADDR_RESULT  = 8'hA0;
    localparam logic [7:0]  ADDR_ID      = 8'h81;
    localparam logic [31:0] CHIP_ID      = 32'h414D5331;

    localparam logic [2:0]  BEAT_FIRST_W = 3'd0;
    localparam logic [2:0]  BEAT_FEAT_LO = 3'd6;
    localparam logic [2:0]  BEAT_LAST    = 3'd7;

    typedef enum logic [3:0] {
        IDLE,
`ifdef WB_JOB_ID_CHECK_EN
        IDCHK0,
        IDCHK1,
`endif
        WR,
        GAP,
        WAIT,
        RD0,
        RD1,
        HOLD
    } state_t;

    // Beats 0..5 carry the weight sets, 6..7 the feature word.
    function automatic logic [7:0] beat_addr(input logic [2:0] beat, input logic [2:0] idx);
        logic [7:0] a;
        case (beat)
            3'd0:    a = ADDR_W0_LO;
            3'd1:    a = ADDR_W0_HI;
            3'd2:    a = ADDR_W0_TOP;
            3'd3:    a = ADDR_W1_LO;
            3'd4:    a = ADDR_W1_HI;
            3'd5:    a = ADDR_W1_TOP;
            3'd6:    a = ADDR_FEAT_LO | {5'd0, idx};
            default: a = ADDR_FEAT_HI | {5'd0, idx};
        endcase
        return a;
    endfunction

    function automatic logic [31:0] beat_data(input logic [2:0]  beat,
                                              input logic [71:0] wi0,
                                              input logic [71:0] wi1,
                                              input logic [63:0] feat);
        logic [31:0] d;
        case (beat)
            3'd0:    d = wi0[31:0];
            3'd1:    d = wi0[63:32];
            3'd2:    d = {wi0[71:64], 24'h0};
            3'd3:    d = wi1[31:0];
            3'd4:    d = wi1[63:32];
            3'd5:    d = {wi1[71:64], 24'h0};
            3'd6:    d = feat[31:0];
            default: d = feat[63:32];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_beat_timer.sv
// Shared cycle counter: measures WR cycles for the ack timeout and WAIT cycles for engine settle.
module wb_beat_timer #(
    parameter int unsigned WAIT_CYC    = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wr_active_i,
    input  logic wait_active_i,
    output logic ack_timeout_o,
    output logic wait_done_o
);

    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // WR and WAIT are always entered from a non-counting state, so one counter serves both.
    always_comb begin
        cnt_d = '0;
        if (wr_active_i || wait_active_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ack_timeout_o = wr_active_i && (cnt_q == ACK_LAST);
    assign wait_done_o   = wait_active_i && (cnt_q == WAIT_LAST);

endmodule

// File: rtl/wb_job_sequencer.sv
// Job sequencer: streams weight/feature beats to a Wishbone engine, waits, then reads the result.
// Define WB_JOB_ID_CHECK_EN to read and verify the engine ID register after reset.
module wb_job_sequencer
    import wb_map_pkg::*;
#(
    parameter int unsigned WAIT_CYC    = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic        job_load_w,
    input  logic [71:0] job_wi0,
    input  logic [71:0] job_wi1,
    input  logic [63:0] job_feat,
    input  logic [2:0]  job_idx,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    output logic        wb_cyc,
    output logic        wb_str,
    output logic        wb_we,
    input  logic        wb_ack,
    output logic        busy,
    output logic        err
);

    state_t      state_q;
    logic [2:0]  beat_q;
    logic [2:0]  idx_q;
    logic [71:0] wi0_q;
    logic [71:0] wi1_q;
    logic [63:0] feat_q;
    logic [7:0]  wb_addr_q;
    logic [31:0] wb_dout_q;
    logic        wb_cyc_q;
    logic        wb_str_q;
    logic        wb_we_q;
    logic        job_ready_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic        busy_q;
    logic        err_q;

    logic [2:0]  beat_d;
    logic [7:0]  addr_d;
    logic [31:0] dout_d;
    logic [2:0]  idx_sel;
    logic [71:0] wi0_sel;
    logic [71:0] wi1_sel;
    logic [63:0] feat_sel;
    logic        ack_timeout;
    logic        wait_done;

    wb_beat_timer #(
        .WAIT_CYC    (WAIT_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_beat_timer (
        .clk_i         (clk),
        .rst_ni        (rst),
        .wr_active_i   (state_q == WR),
        .wait_active_i (state_q == WAIT),
        .ack_timeout_o (ack_timeout),
        .wait_done_o   (wait_done)
    );

    // The first beat is launched from the live job inputs so the bus goes up on the acceptance edge.
    always_comb begin
        beat_d   = beat_q + 3'd1;
        idx_sel  = idx_q;
        wi0_sel  = wi0_q;
        wi1_sel  = wi1_q;
        feat_sel = feat_q;
        if (state_q == IDLE) begin
            beat_d   = job_load_w ? BEAT_FIRST_W : BEAT_FEAT_LO;
            idx_sel  = job_idx;
            wi0_sel  = job_wi0;
            wi1_sel  = job_wi1;
            feat_sel = job_feat;
        end
        addr_d = beat_addr(beat_d, idx_sel);
        dout_d = beat_data(beat_d, wi0_sel, wi1_sel, feat_sel);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef WB_JOB_ID_CHECK_EN
            state_q     <= IDCHK0;
            job_ready_q <= 1'b0;
`else
            state_q     <= IDLE;
            job_ready_q <= 1'b1;
`endif
            beat_q      <= '0;
            idx_q       <= '0;
            wi0_q       <= '0;
            wi1_q       <= '0;
            feat_q      <= '0;
            wb_addr_q   <= '0;
            wb_dout_q   <= '0;
            wb_cyc_q    <= 1'b0;
            wb_str_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
`ifdef WB_JOB_ID_CHECK_EN
                IDCHK0: begin
                    wb_addr_q <= ADDR_ID;
                    wb_cyc_q  <= 1'b1;
                    wb_str_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= IDCHK1;
                end
                IDCHK1: begin
                    if (wb_din != CHIP_ID) begin
                        err_q <= 1'b1;
                    end
                    wb_addr_q   <= '0;
                    wb_cyc_q    <= 1'b0;
                    wb_str_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
`endif
                IDLE: begin
                    if (job_valid && job_ready_q) begin
                        idx_q       <= job_idx;
                        wi0_q       <= job_wi0;
                        wi1_q       <= job_wi1;
                        feat_q      <= job_feat;
                        beat_q      <= beat_d;
                        wb_addr_q   <= addr_d;
                        wb_dout_q   <= dout_d;
                        wb_cyc_q    <= 1'b1;
                        wb_str_q    <= 1'b1;
                        wb_we_q     <= 1'b1;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WR;
                    end
                end
                WR: begin
                    if (wb_ack || ack_timeout) begin
                        wb_addr_q <= '0;
                        wb_dout_q <= '0;
                        wb_cyc_q  <= 1'b0;
                        wb_str_q  <= 1'b0;
                        wb_we_q   <= 1'b0;
                    end
                    if (wb_ack) begin
                        state_q <= GAP;
                    end else if (ack_timeout) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                GAP: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q <= WAIT;
                    end else begin
                        beat_q    <= beat_d;
                        wb_addr_q <= addr_d;
                        wb_dout_q <= dout_d;
                        wb_cyc_q  <= 1'b1;
                        wb_str_q  <= 1'b1;
                        wb_we_q   <= 1'b1;
                        state_q   <= WR;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        wb_addr_q <= ADDR_RESULT;
                        wb_dout_q <= '0;
                        wb_cyc_q  <= 1'b1;
                        wb_str_q  <= 1'b1;
                        wb_we_q   <= 1'b0;
                        state_q   <= RD0;
                    end
                end
                RD0: begin
                    state_q <= RD1;
                end
                RD1: begin
                    res_data_q  <= wb_din;
                    res_valid_q <= 1'b1;
                    wb_addr_q   <= '0;
                    wb_cyc_q    <= 1'b0;
                    wb_str_q    <= 1'b0;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    wb_addr_q   <= '0;
                    wb_dout_q   <= '0;
                    wb_cyc_q    <= 1'b0;
                    wb_str_q    <= 1'b0;
                    wb_we_q     <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign job_ready = job_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign wb_addr   = wb_addr_q;
    assign wb_dout   = wb_dout_q;
    assign wb_cyc    = wb_cyc_q;
    assign wb_str    = wb_str_q;
    assign wb_we     = wb_we_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
